// File: rtl/weighted_rr_arbiter_pkg.sv
// Shared types and helpers for the weighted round-robin arbiter.
// Provides the FSM state encoding, the default burst-field width and a clog2 helper.
package arb_pkg;

  typedef enum logic {
    IDLE  = 1'b0,
    GRANT = 1'b1
  } arb_state_t;

  localparam int unsigned DEF_BLEN_W = 8;

  function automatic int unsigned clog2(input int unsigned v);
    int unsigned r;
    r = 0;
    for (int unsigned i = 0; i < 32; i++) begin
      if ((32'd1 << i) < v) r = i + 1;
    end
    return r;
  endfunction

endpackage

// File: rtl/weighted_rr_arbiter_if.sv
// Bus bundle between the source FIFOs / SRAM FIFO sink and the arbiter.
// The master modport is the environment side; the slave modport is the arbiter side.
interface weighted_rr_arbiter_if
  import arb_pkg::*;
#(
    parameter int unsigned CHANNELS = 6,
    parameter int unsigned DSIZE    = 32,
    parameter int unsigned BLEN_W   = DEF_BLEN_W,
    parameter int unsigned CH_W     = clog2(CHANNELS)
);

    logic [CHANNELS-1:0]        WRITE_REQ;
    logic [CHANNELS-1:0]        HOLD_REQ;
    logic [CHANNELS-1:0]        CH_ENABLE;
    logic [CHANNELS*BLEN_W-1:0] BURST_LEN;
    logic [CHANNELS*DSIZE-1:0]  DATA_IN;
    logic [CHANNELS-1:0]        READ_GRANT;
    logic                       READY_IN;
    logic                       WRITE_OUT;
    logic [DSIZE-1:0]           DATA_OUT;
    logic [CH_W-1:0]            ACTIVE_CH;
    logic                       BUSY;

    modport master (
        output WRITE_REQ, HOLD_REQ, CH_ENABLE, BURST_LEN, DATA_IN, READY_IN,
        input  READ_GRANT, WRITE_OUT, DATA_OUT, ACTIVE_CH, BUSY
    );

    modport slave (
        input  WRITE_REQ, HOLD_REQ, CH_ENABLE, BURST_LEN, DATA_IN, READY_IN,
        output READ_GRANT, WRITE_OUT, DATA_OUT, ACTIVE_CH, BUSY
    );

endinterface

// File: rtl/weighted_rr_arbiter_rr_next_select.sv
// Combinational round-robin picker: first eligible index strictly after i_ptr,
// wrapping modulo CHANNELS, via rotate / priority-encode / unrotate.
module rr_next_select
  import arb_pkg::*;
#(
    parameter int unsigned CHANNELS = 6,
    parameter int unsigned CH_W     = clog2(CHANNELS)
) (
    input  logic [CHANNELS-1:0] i_elig,
    input  logic [CH_W-1:0]     i_ptr,
    output logic [CH_W-1:0]     o_next,
    output logic                o_found
);

    logic [CHANNELS-1:0] w_rot;
    logic [CH_W-1:0]     w_off;

    always_comb begin
        w_rot = '0;
        for (int unsigned k = 0; k < CHANNELS; k++) begin
            int unsigned idx;
            idx = (int'(i_ptr) + 1 + k) % CHANNELS;
            w_rot[k[CH_W-1:0]] = i_elig[idx[CH_W-1:0]];
        end
    end

    always_comb begin
        w_off   = '0;
        o_found = 1'b0;
        for (int unsigned k = 0; k < CHANNELS; k++) begin
            if (w_rot[k[CH_W-1:0]] && !o_found) begin
                w_off   = k[CH_W-1:0];
                o_found = 1'b1;
            end
        end
    end

    always_comb begin
        int unsigned sum;
        sum    = (int'(i_ptr) + 1 + int'(w_off)) % CHANNELS;
        o_next = sum[CH_W-1:0];
    end

endmodule

// File: rtl/weighted_rr_arbiter.sv
// Weighted round-robin arbiter merging per-source FWFT FIFOs into one sink.
// One owner at a time; per-channel burst limits weight the rotation, HOLD_REQ overrides it.
module weighted_rr_arbiter
  import arb_pkg::*;
#(
    parameter int unsigned CHANNELS = 6,
    parameter int unsigned DSIZE    = 32,
    parameter int unsigned BLEN_W   = DEF_BLEN_W,
    parameter int unsigned CH_W     = clog2(CHANNELS)
) (
    input logic             BUS_CLK,
    input logic             BUS_RST,
    weighted_rr_arbiter_if.slave bus
);

    arb_state_t          r_state;
    logic [CH_W-1:0]     r_owner;
    logic [CH_W-1:0]     r_ptr;
    logic [BLEN_W-1:0]   r_cnt;
    logic [BLEN_W-1:0]   r_blen;
    logic                r_wout;
    logic [DSIZE-1:0]    r_dout;

    logic [CHANNELS-1:0] w_elig;
    logic [CH_W-1:0]     w_next;
    logic                w_found;
    logic                w_req;
    logic                w_hold;
    logic                w_en;
    logic                w_lim;
    logic                w_last;
    logic                w_pop;
    logic                w_exit;

    assign w_elig = (bus.WRITE_REQ | bus.HOLD_REQ) & bus.CH_ENABLE;

    rr_next_select #(
        .CHANNELS (CHANNELS),
        .CH_W     (CH_W)
    ) u_sel (
        .i_elig  (w_elig),
        .i_ptr   (r_ptr),
        .o_next  (w_next),
        .o_found (w_found)
    );

    always_comb begin
        w_req  = bus.WRITE_REQ[r_owner];
        w_hold = bus.HOLD_REQ[r_owner];
        w_en   = bus.CH_ENABLE[r_owner];
        w_lim  = (r_blen != '0) && (r_cnt == r_blen);
        w_pop  = (r_state == GRANT) && w_req && bus.READY_IN && w_en && !w_lim;
        // Widened by one bit so a saturated counter cannot wrap into a false match.
        w_last = w_pop && (r_blen != '0) &&
                 (({1'b0, r_cnt} + {{BLEN_W{1'b0}}, 1'b1}) == {1'b0, r_blen});
        w_exit = !w_en || (!w_hold && (!w_req || w_lim || w_last));
        bus.READ_GRANT = '0;
        if (w_pop) bus.READ_GRANT[r_owner] = 1'b1;
    end

    always_ff @(posedge BUS_CLK or posedge BUS_RST) begin
        if (BUS_RST) begin
            r_state <= IDLE;
            r_owner <= '0;
            r_ptr   <= CH_W'(CHANNELS - 1);
            r_cnt   <= '0;
            r_blen  <= '0;
            r_wout  <= 1'b0;
            r_dout  <= '0;
        end else begin
            r_wout <= w_pop;
            if (w_pop) r_dout <= bus.DATA_IN[int'(r_owner)*DSIZE +: DSIZE];
            case (r_state)
                IDLE: begin
                    if (w_found) begin
                        r_owner <= w_next;
                        r_ptr   <= w_next;
                        r_cnt   <= '0;
                        r_blen  <= bus.BURST_LEN[int'(w_next)*BLEN_W +: BLEN_W];
                        r_state <= GRANT;
                    end
                end
                GRANT: begin
                    if (w_pop && !(&r_cnt)) r_cnt <= r_cnt + 1'b1;
                    if (w_exit) r_state <= IDLE;
                end
                default: r_state <= IDLE;
            endcase
        end
    end

    assign bus.WRITE_OUT = r_wout;
    assign bus.DATA_OUT  = r_dout;
    assign bus.ACTIVE_CH = r_owner;
    assign bus.BUSY      = (r_state == GRANT);

endmodule

// File: tb/tb_weighted_rr_arbiter.sv
// Directed self-checking bench for weighted_rr_arbiter with hand-computed expectations.
// Sources are modelled as word counters whose FWFT data is a channel/sequence tag.
module tb_weighted_rr_arbiter;

    localparam int CH = 6;
    localparam int DW = 32;
    localparam int BW = 8;

    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    weighted_rr_arbiter_if #(.CHANNELS(CH), .DSIZE(DW), .BLEN_W(BW)) bus ();

    weighted_rr_arbiter #(.CHANNELS(CH), .DSIZE(DW), .BLEN_W(BW)) dut (
        .BUS_CLK (clk),
        .BUS_RST (rst),
        .bus     (bus.slave)
    );

    int n_cmp = 0;
    int n_mis = 0;
    int src_cnt [CH];
    int src_seq [CH];

    function automatic logic [31:0] dword(input int i, input int s);
        return 32'hA000_0000 | (32'(i) << 24) | 32'(s);
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_mis++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic drive_srcs();
        for (int i = 0; i < CH; i++) begin
            bus.WRITE_REQ[i]         = (src_cnt[i] > 0);
            bus.DATA_IN[i*DW +: DW]  = dword(i, src_seq[i]);
        end
    endtask

    task automatic clear_srcs();
        for (int i = 0; i < CH; i++) begin
            src_cnt[i] = 0;
            src_seq[i] = 0;
        end
        bus.HOLD_REQ  = '0;
        bus.CH_ENABLE = '1;
        bus.BURST_LEN = '0;
        bus.READY_IN  = 1'b1;
        drive_srcs();
    endtask

    // Advance to the next cycle; the source model pops on the grant seen this cycle.
    task automatic cyc();
        logic [CH-1:0] g;
        g = bus.READ_GRANT;
        @(posedge clk);
        #1;
        for (int i = 0; i < CH; i++) begin
            if (g[i] && src_cnt[i] > 0) begin
                src_cnt[i]--;
                src_seq[i]++;
            end
        end
        drive_srcs();
    endtask

    task automatic step();
        cyc();
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        drive_srcs();
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        #1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: observed timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int w2, w3, ovl, starts;
        logic prev_busy;
        int wk [CH];
        int rdy_t [10] = '{1, 0, 0, 1, 1, 1, 1, 1, 1, 1};
        int rg_t  [10] = '{1, 0, 0, 1, 1, 1, 1, 1, 0, 0};
        int wo_t  [10] = '{0, 1, 0, 0, 1, 1, 1, 1, 1, 0};
        int d_t   [10] = '{-1, 0, 0, 0, 1, 2, 3, 4, 5, 5};

        // Reset state
        clear_srcs();
        #1 rst = 1'b1;
        #1;
        check("rst_grant", 32'(bus.READ_GRANT), 0);
        check("rst_wout",  32'(bus.WRITE_OUT), 0);
        check("rst_dout",  bus.DATA_OUT, 0);
        check("rst_active", 32'(bus.ACTIVE_CH), 0);
        check("rst_busy",  32'(bus.BUSY), 0);

        // Single channel, 3 words, unlimited burst
        src_cnt[0] = 3;
        do_reset();
        check("t1_c0_busy", 32'(bus.BUSY), 0);
        check("t1_c0_grant", 32'(bus.READ_GRANT), 0);
        step();
        check("t1_c1_busy", 32'(bus.BUSY), 1);
        check("t1_c1_active", 32'(bus.ACTIVE_CH), 0);
        check("t1_c1_grant", 32'(bus.READ_GRANT), 1);
        check("t1_c1_wout", 32'(bus.WRITE_OUT), 0);
        step();
        check("t1_c2_grant", 32'(bus.READ_GRANT), 1);
        check("t1_c2_wout", 32'(bus.WRITE_OUT), 1);
        check("t1_c2_dout", bus.DATA_OUT, dword(0, 0));
        step();
        check("t1_c3_grant", 32'(bus.READ_GRANT), 1);
        check("t1_c3_dout", bus.DATA_OUT, dword(0, 1));
        step();
        check("t1_c4_grant", 32'(bus.READ_GRANT), 0);
        check("t1_c4_wout", 32'(bus.WRITE_OUT), 1);
        check("t1_c4_dout", bus.DATA_OUT, dword(0, 2));
        step();
        check("t1_c5_busy", 32'(bus.BUSY), 0);
        check("t1_c5_wout", 32'(bus.WRITE_OUT), 0);

        // All channels requesting, burst 4: rotation 0..5,0
        clear_srcs();
        for (int i = 0; i < CH; i++) begin
            src_cnt[i] = 1000;
            bus.BURST_LEN[i*BW +: BW] = 8'd4;
            wk[i] = 0;
        end
        do_reset();
        for (int g = 0; g < 7; g++) begin
            int ch, pv;
            ch = g % CH;
            pv = (g + CH - 1) % CH;
            if (g > 0) step();
            check("t2_idle_busy", 32'(bus.BUSY), 0);
            check("t2_idle_grant", 32'(bus.READ_GRANT), 0);
            if (g > 0) begin
                check("t2_idle_wout", 32'(bus.WRITE_OUT), 1);
                check("t2_idle_dout", bus.DATA_OUT, dword(pv, wk[pv] - 1));
            end
            for (int k = 0; k < 4; k++) begin
                step();
                check("t2_busy", 32'(bus.BUSY), 1);
                check("t2_active", 32'(bus.ACTIVE_CH), 32'(ch));
                check("t2_grant", 32'(bus.READ_GRANT), 32'(1) << ch);
                if (k > 0) check("t2_dout", bus.DATA_OUT, dword(ch, wk[ch] + k - 1));
            end
            wk[ch] += 4;
        end

        // Weighting 8:2 over 100 grants
        clear_srcs();
        src_cnt[2] = 1000;
        src_cnt[3] = 1000;
        bus.BURST_LEN[2*BW +: BW] = 8'd8;
        bus.BURST_LEN[3*BW +: BW] = 8'd2;
        do_reset();
        w2 = 0; w3 = 0; ovl = 0; starts = 0; prev_busy = 1'b0;
        for (int c = 0; c < 600; c++) begin
            if (c > 0) step();
            if (bus.READ_GRANT[2]) w2++;
            if (bus.READ_GRANT[3]) w3++;
            if ($countones(bus.READ_GRANT) > 1) ovl++;
            if (bus.BUSY && !prev_busy) starts++;
            prev_busy = bus.BUSY;
        end
        check("t3_words_ch2", 32'(w2), 400);
        check("t3_words_ch3", 32'(w3), 100);
        check("t3_overlap", 32'(ovl), 0);
        check("t3_grants", 32'(starts), 100);

        // Hold with empty source blocks channel 1 until HOLD_REQ falls
        clear_srcs();
        src_cnt[0] = 2;
        src_cnt[1] = 5;
        bus.BURST_LEN[0*BW +: BW] = 8'd3;
        bus.HOLD_REQ[0] = 1'b1;
        do_reset();
        check("t4_c0_busy", 32'(bus.BUSY), 0);
        step();
        check("t4_c1_grant", 32'(bus.READ_GRANT), 1);
        step();
        check("t4_c2_grant", 32'(bus.READ_GRANT), 1);
        check("t4_c2_dout", bus.DATA_OUT, dword(0, 0));
        step();
        check("t4_c3_grant", 32'(bus.READ_GRANT), 0);
        check("t4_c3_dout", bus.DATA_OUT, dword(0, 1));
        for (int k = 0; k < 3; k++) begin
            step();
            check("t4_hold_grant", 32'(bus.READ_GRANT), 0);
            check("t4_hold_busy", 32'(bus.BUSY), 1);
            check("t4_hold_active", 32'(bus.ACTIVE_CH), 0);
            check("t4_hold_wout", 32'(bus.WRITE_OUT), 0);
        end
        cyc();
        bus.HOLD_REQ[0] = 1'b0;
        #1;
        check("t4_drop_busy", 32'(bus.BUSY), 1);
        check("t4_drop_grant", 32'(bus.READ_GRANT), 0);
        step();
        check("t4_idle_busy", 32'(bus.BUSY), 0);
        step();
        check("t4_next_active", 32'(bus.ACTIVE_CH), 1);
        check("t4_next_grant", 32'(bus.READ_GRANT), 2);

        // READY_IN stalls on channel 4
        clear_srcs();
        src_cnt[4] = 6;
        do_reset();
        check("t5_c0_busy", 32'(bus.BUSY), 0);
        for (int c = 0; c < 10; c++) begin
            cyc();
            bus.READY_IN = rdy_t[c][0];
            #1;
            check("t5_grant", 32'(bus.READ_GRANT), rg_t[c] != 0 ? 32'h10 : 32'h0);
            check("t5_wout", 32'(bus.WRITE_OUT), 32'(wo_t[c]));
            check("t5_dout", bus.DATA_OUT, d_t[c] < 0 ? 32'h0 : dword(4, d_t[c]));
        end
        check("t5_end_busy", 32'(bus.BUSY), 0);
        bus.READY_IN = 1'b1;

        // Channel disable mid-burst, then reset mid-burst
        clear_srcs();
        src_cnt[1] = 1000;
        src_cnt[2] = 1000;
        bus.BURST_LEN[2*BW +: BW] = 8'd3;
        do_reset();
        step();
        check("t6_c1_active", 32'(bus.ACTIVE_CH), 1);
        check("t6_c1_grant", 32'(bus.READ_GRANT), 2);
        step();
        check("t6_c2_grant", 32'(bus.READ_GRANT), 2);
        cyc();
        bus.CH_ENABLE[1] = 1'b0;
        #1;
        check("t6_dis_grant", 32'(bus.READ_GRANT), 0);
        check("t6_dis_wout", 32'(bus.WRITE_OUT), 1);
        step();
        check("t6_c4_busy", 32'(bus.BUSY), 0);
        check("t6_c4_wout", 32'(bus.WRITE_OUT), 0);
        step();
        check("t6_c5_active", 32'(bus.ACTIVE_CH), 2);
        check("t6_c5_grant", 32'(bus.READ_GRANT), 4);
        step();
        step();
        step();
        check("t6_c8_busy", 32'(bus.BUSY), 0);
        check("t6_c8_dout", bus.DATA_OUT, dword(2, 2));
        step();
        check("t6_c9_active", 32'(bus.ACTIVE_CH), 2);
        check("t6_c9_grant", 32'(bus.READ_GRANT), 4);
        step();
        check("t6_c10_wout", 32'(bus.WRITE_OUT), 1);
        #1 rst = 1'b1;
        #1;
        check("t6_rst_grant", 32'(bus.READ_GRANT), 0);
        check("t6_rst_wout", 32'(bus.WRITE_OUT), 0);
        check("t6_rst_dout", bus.DATA_OUT, 0);
        check("t6_rst_active", 32'(bus.ACTIVE_CH), 0);
        check("t6_rst_busy", 32'(bus.BUSY), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
        $finish;
    end

endmodule

// File: doc/weighted_rr_arbiter.md
Name: weighted_rr_arbiter

Overview:
Parametrised successor to the fixed-width round-robin arbiter that merges the per-source readout FIFOs (FE RX channels, TDC, TLU) into the single SRAM FIFO write path.
- Generalises channel count and data width.
- Adds per-channel burst limits, so one channel keeps the grant for up to N words before rotation.
- Adds a runtime channel-enable mask and hold/preempt semantics that override the burst limit.
- Sits between the source FWFT FIFOs and the SRAM FIFO input.

Parameters:
CHANNELS, 6, number of requesting sources (2..16)
DSIZE, 32, data word width
BLEN_W, 8, width of each per-channel burst-length field; 0 means unlimited
CH_W, $clog2(CHANNELS), width of channel index

Ports:
BUS_CLK  input  1  single clock for all logic
BUS_RST  input  1  asynchronous, active-high reset
WRITE_REQ  input  CHANNELS  source i not empty (FWFT data valid)
HOLD_REQ  input  CHANNELS  source i requests to keep the grant (preempt/hold)
CH_ENABLE  input  CHANNELS  channel participates in arbitration when 1
BURST_LEN  input  CHANNELS*BLEN_W  per-channel word limit per grant; quasi-static
DATA_IN  input  CHANNELS*DSIZE  source data; channel i at [i*DSIZE +: DSIZE]
READ_GRANT  output  CHANNELS  one-hot pop strobe to source FIFO
READY_IN  input  1  sink can accept a word next cycle
WRITE_OUT  output  1  DATA_OUT valid, one-cycle strobe per word
DATA_OUT  output  DSIZE  registered output word
ACTIVE_CH  output  CH_W  index of current owner
BUSY  output  1  state == GRANT

Behaviour:
- Reset (async, BUS_RST=1):
  - state=IDLE; owner=0; rr pointer=CHANNELS-1, so channel 0 wins first; burst counter=0.
  - WRITE_OUT=0, DATA_OUT=0, READ_GRANT=0, ACTIVE_CH=0, BUSY=0.
- Eligibility: elig[i] = (WRITE_REQ[i] | HOLD_REQ[i]) & CH_ENABLE[i].
- IDLE:
  - If any elig, select the first eligible index strictly after the rr pointer, wrapping modulo CHANNELS.
  - Register owner and ACTIVE_CH, set pointer=owner, clear the counter, go to GRANT.
  - Arbitration takes exactly one cycle. With no eligible channel, stay in IDLE.
- GRANT, word transfer:
  - READ_GRANT[owner] = WRITE_REQ[owner] & READY_IN & CH_ENABLE[owner] & (limit not reached). It is combinational, at most one bit high.
  - On READ_GRANT, the next cycle has DATA_OUT = DATA_IN[owner] (captured on the same edge) and WRITE_OUT=1; otherwise WRITE_OUT=0. DATA_OUT holds its last value.
  - Counter increments per granted word and saturates at 2^BLEN_W-1.
  - limit reached = BURST_LEN[owner]!=0 & cnt==BURST_LEN[owner].
- GRANT, exit to IDLE:
  - Condition (a): HOLD_REQ[owner]=0 and (WRITE_REQ[owner]=0, or limit reached, or the cycle's grant makes cnt+1==limit).
  - Condition (b): CH_ENABLE[owner]=0, regardless of HOLD_REQ.
  - HOLD_REQ[owner]=1 keeps GRANT even when the source is empty or the limit is reached. While held at the limit, no words are popped until the counter is reset; the counter resets when HOLD_REQ falls.
- Latency:
  - Request in cycle n (IDLE) gives BUSY and READ_GRANT in cycle n+1, and WRITE_OUT in cycle n+2.
  - There is one dead cycle between consecutive grants.
  - Peak throughput within a grant is one word per cycle.
- READY_IN=0 stalls popping but does not release the grant.
- Simultaneous requests are resolved by round-robin only; there is no fixed priority. The burst limit gives weighting.
- BURST_LEN changes take effect only at the next grant start; the value is sampled into a register when leaving IDLE.
- The word transfer issued on the exit cycle completes: its WRITE_OUT appears the following cycle, while the FSM is in IDLE.
- Reset asserted mid-burst aborts immediately. No further READ_GRANT or WRITE_OUT, and state is lost.

Decomposition:
- Package arb_pkg:
  - state encoding (IDLE, GRANT)
  - clog2 helper function
  - default BLEN_W
- Sub-module rr_next_select: purely combinational.
  - Inputs: elig vector and pointer. Outputs: next index and a found flag.
  - Implemented by rotate, priority-encode, unrotate. Parametrised by CHANNELS.
- Everything else (FSM, counter, output register) lives in weighted_rr_arbiter.

Test Plan:
- Reset, then WRITE_REQ=6'b000001 with 3 words, BURST_LEN=0, READY_IN=1: READ_GRANT[0] high for 3 cycles starting 1 cycle after the request; WRITE_OUT for 3 cycles 1 cycle later with matching data; return to IDLE.
- All 6 channels request continuously with BURST_LEN=4 each: owners rotate 0,1,2,3,4,5,0; exactly 4 words per grant; 1 idle cycle between grants.
- Channel 2 with BURST_LEN=8 and channel 3 with BURST_LEN=2, both always requesting: 8:2 word ratio over 100 grants; no READ_GRANT overlap.
- HOLD_REQ[0]=1 with the source emptying at word 2 and BURST_LEN=3: grant is held with no pops; another channel's request is ignored until HOLD_REQ falls, then channel 1 wins the next arbitration.
- READY_IN toggled 1,0,0,1 during a grant: READ_GRANT asserted only where READY_IN=1; no data loss or duplication against a scoreboard.
- CH_ENABLE[1] cleared mid-burst: release within one cycle and channel 1 is skipped thereafter. BUS_RST asserted mid-burst: all outputs go to 0 asynchronously.
